pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control unit that owns the program counter and steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It holds the architectural PC, computes the next PC (sequential, branch, JAL, JALR) and commits it only at writeback. It also handshakes with instruction and data memory and emits the register-file and instruction-register write strobes. It sits between the decoder/ALU compare output and the memories, and replaces free-running PC update in the multi-cycle core.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clock  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction word valid this cycle
- ir_write  out  1  one-cycle pulse: latch instruction register
- is_jal, is_jalr, is_branch  in  1 each  decoded control-transfer class
- br_taken  in  1  branch comparison result from ALU
- halt  in  1  decoded halt/ecall
- mem_op  in  1  instruction needs MEM state
- mem_ack  in  1  data memory access complete
- wb_en  in  1  instruction writes rd
- imm  in  XLEN  sign-extended immediate
- rs1_val  in  XLEN  rs1 operand, used by JALR
- pc  out  XLEN  current architectural PC
- pc_plus4  out  XLEN  pc + 4, link value for rd
- reg_write  out  1  register-file write strobe
- retire  out  1  one-cycle pulse per committed instruction
- halted  out  1  high in HALT
- trap  out  1  high in TRAP (always 0 without macro)
- state  out  3  current state, debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- FETCH: imem_req=1. On imem_ack, pulse ir_write and go to DECODE. Otherwise stay, with no timeout.
- DECODE: single cycle. halt=1 goes to HALT, else EXEC.
- EXEC: register npc and go to MEM if mem_op=1, else WB.
  - npc priority: is_jal gives pc+imm; else is_jalr gives (rs1_val+imm)&~1; else is_branch&br_taken gives pc+imm; else pc+4.
- MEM: wait for mem_ack, then go to WB.
- WB: reg_write=wb_en, retire=1, pc<=npc, then go to FETCH.
- HALT: absorbing. All strobes 0 and halted=1. Exit only via reset.
- Outputs are Moore-decoded from state. pc changes only in WB.
- Arithmetic is modulo 2^XLEN. 32'hFFFF_FFFC + 4 = 0, with no flag.
- Decoder inputs are sampled in EXEC and must be stable from DECODE through EXEC. mem_ack and imem_ack are ignored outside MEM and FETCH.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, npc=RESET_PC, imem_req=1, ir_write=0, reg_write=0, retire=0, halted=0, trap=0.
- Reset mid-instruction aborts it: no reg_write, pc reloads RESET_PC. Fetch resumes the cycle after reset deasserts.
- Minimum latency is 4 cycles per non-memory instruction (ack in first FETCH cycle) and 5 cycles per memory instruction. Each wait cycle adds 1.
- pc_plus4 is combinational from pc and valid every cycle.
- retire and reg_write are coincident, both in the WB cycle.

## Configuration
- PC_MISALIGN_TRAP_EN defined: in EXEC, if the computed target has bits [1:0]≠0, go to TRAP instead of MEM/WB.
  - No pc update, no reg_write, no retire.
  - trap=1 until reset.
- Not defined: npc[1:0] forced to 2'b00, TRAP unreachable, trap tied 0.

## Structure
- Shared package pc_seq_pkg: state enum with the encodings above, default XLEN, and PC_INC=4.
- Sub-module pc_next_calc: combinational next-PC selector and adders (inputs pc, imm, rs1_val, class flags, br_taken; outputs npc, misaligned). The FSM and pc register stay in pc_sequencer.

## Test plan
- Reset, imem_ack held 1, all class flags 0: pc goes 0→4→8 with retire every 4 cycles. Asserting reset in DECODE returns pc to 0 with no reg_write.
- pc=0x100, is_branch=1, br_taken=1, imm=0xFFFF_FFF0: after WB, pc=0xF0. Same with br_taken=0: pc=0x104.
- is_jal=1 and is_branch=1 together, imm=0x20 at pc=0x40: pc=0x60 (JAL wins). reg_write=1 when wb_en=1, pc_plus4=0x44 during WB.
- is_jalr=1, rs1_val=0x1001, imm=0x4: pc=0x1004. imem_ack delayed 3 cycles: retire interval becomes 7.
- mem_op=1, mem_ack after 2 cycles: sequence is FETCH, DECODE, EXEC, MEM, MEM, WB. pc=0xFFFF_FFFC sequential wraps to 0. halt=1 gives halted=1 and pc frozen.
- With PC_MISALIGN_TRAP_EN, JAL imm=0x6 at pc=0: trap=1, state=6, pc stays 0, no retire. Without the macro, pc=0x4.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// ============================================================================
// pc_seq_pkg : shared state encoding and constants for the PC sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_INC       = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
// pc_next_calc : combinational next-PC selection (seq / branch / JAL / JALR)
// Config macro : PC_MISALIGN_TRAP_EN (report misaligned targets, else align)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic            br_taken,
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;

  always_comb begin
    pc_plus4 = pc + XLEN'(PC_INC);
    pc_rel   = pc + imm;
    jalr_tgt = (rs1_val + imm) & ~XLEN'(1);
    target   = pc_plus4;
    if (is_jal) begin
      target = pc_rel;
    end else if (is_jalr) begin
      target = jalr_tgt;
    end else if (is_branch && br_taken) begin
      target = pc_rel;
    end
`ifdef PC_MISALIGN_TRAP_EN
    npc        = target;
    misaligned = |target[1:0];
`else
    // Without trapping, low bits are simply dropped so the PC stays word aligned.
    npc        = target & ~XLEN'(3);
    misaligned = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control, owns the PC
// Config macro : PC_MISALIGN_TRAP_EN (misaligned targets enter TRAP)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            ir_write,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic            br_taken,
  input  logic            halt,
  input  logic            mem_op,
  input  logic            mem_ack,
  input  logic            wb_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            reg_write,
  output logic            retire,
  output logic            halted,
  output logic            trap,
  output logic [2:0]      state
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] calc_npc;
  logic            calc_misaligned;

  pc_next_calc #(
    .XLEN (XLEN)
  ) u_pc_next_calc (
    .pc         (pc_q),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .is_branch  (is_branch),
    .br_taken   (br_taken),
    .npc        (calc_npc),
    .pc_plus4   (pc_plus4),
    .misaligned (calc_misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        // Target is captured here so WB does not depend on decoder stability.
        npc_d = calc_npc;
        if (calc_misaligned) begin
          state_d = ST_TRAP;
        end else begin
          state_d = mem_op ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_write = wb_en;
        retire    = 1'b1;
        pc_d      = npc_q;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign trap = (state_q == ST_TRAP);
`else
  assign trap = 1'b0;
`endif

  assign pc    = pc_q;
  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes expected outcomes, a
// negedge monitor pops them whenever the DUT retires, halts or traps.
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, ir_write;
  logic        is_jal, is_jalr, is_branch, br_taken, halt, mem_op, mem_ack, wb_en;
  logic [31:0] imm, rs1_val, pc, pc_plus4;
  logic        reg_write, retire, halted, trap;
  logic [2:0]  state;

  pc_sequencer #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_write(ir_write), .is_jal(is_jal), .is_jalr(is_jalr), .is_branch(is_branch),
    .br_taken(br_taken), .halt(halt), .mem_op(mem_op), .mem_ack(mem_ack),
    .wb_en(wb_en), .imm(imm), .rs1_val(rs1_val), .pc(pc), .pc_plus4(pc_plus4),
    .reg_write(reg_write), .retire(retire), .halted(halted), .trap(trap),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef enum int {K_RETIRE = 0, K_HALT = 1, K_TRAP = 2} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        rw;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] mpc   = RESET_PC;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: compares DUT events against the scoreboard queue.
  initial begin
    exp_t        e;
    logic        pend = 1'b0;
    logic [31:0] pend_pc = '0;
    logic        halt_seen = 1'b0;
    logic        trap_seen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend = 1'b0; halt_seen = 1'b0; trap_seen = 1'b0;
      end else begin
        if (pend) begin
          check("pc_after_wb", pc, pend_pc);
          pend = 1'b0;
        end
        if (state == 3'd0 && imem_ack) check("ir_write_on_ack", 32'(ir_write), 32'd1);
        if (retire) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_retire: got retire=1 expected none (pc=%h)", pc);
          end else begin
            e = sbq.pop_front();
            check("retire_kind", 32'(retire), 32'(e.kind == K_RETIRE));
            check("pc_at_wb", pc, e.pc);
            check("pc_plus4", pc_plus4, e.pc + 32'd4);
            check("reg_write", 32'(reg_write), 32'(e.rw));
            check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
            pend = 1'b1; pend_pc = e.npc;
          end
        end else begin
          check("no_stray_reg_write", 32'(reg_write), 32'd0);
        end
        if (halted && !halt_seen) begin
          halt_seen = 1'b1;
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_halt: got halted=1 expected 0");
          end else begin
            e = sbq.pop_front();
            check("halt_kind", 32'(e.kind), 32'(K_HALT));
            check("halt_pc", pc, e.pc);
            check("halt_state", 32'(state), 32'd5);
            check("halt_imem_req", 32'(imem_req), 32'd0);
          end
        end
        if (trap && !trap_seen) begin
          trap_seen = 1'b1;
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_trap: got trap=1 expected 0");
          end else begin
            e = sbq.pop_front();
            check("trap_kind", 32'(e.kind), 32'(K_TRAP));
            check("trap_pc", pc, e.pc);
            check("trap_state", 32'(state), 32'd6);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    sbq.delete();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_imem_req", 32'(imem_req), 32'd1);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    reset = 1'b0;
    mpc = RESET_PC;
  endtask

  // Called at posedge+1 with the DUT in its first FETCH cycle; returns at the
  // next FETCH, or once HALT/TRAP is reached.
  task automatic issue(input logic jal, input logic jalr, input logic br, input logic tk,
                       input logic hlt, input logic mop, input logic wben,
                       input logic [31:0] im, input logic [31:0] rs,
                       input int fd, input int md, output kind_t k);
    exp_t        e;
    logic [31:0] tgt;
    int          mcnt = 0;
    int          guard = 0;
    if (jal)            tgt = mpc + im;
    else if (jalr)      tgt = (rs + im) & 32'hFFFF_FFFE;
    else if (br && tk)  tgt = mpc + im;
    else                tgt = mpc + 32'd4;
    e.kind  = hlt ? K_HALT : K_RETIRE;
    e.pc    = mpc;
    e.rw    = wben;
    e.start = cyc;
    e.lat   = fd + 4 + (mop ? md + 1 : 0);
`ifdef PC_MISALIGN_TRAP_EN
    e.npc = tgt;
    if (!hlt && tgt[1:0] != 2'b00) e.kind = K_TRAP;
`else
    e.npc = tgt & 32'hFFFF_FFFC;
`endif
    sbq.push_back(e);
    if (e.kind == K_RETIRE) mpc = e.npc;
    k = e.kind;
    is_jal = jal; is_jalr = jalr; is_branch = br; br_taken = tk; halt = hlt;
    mem_op = mop; wb_en = wben; imm = im; rs1_val = rs;
    imem_ack = (fd == 0);
    mem_ack = 1'($urandom_range(0, 1));
    for (int i = 0; i < fd; i++) begin
      @(posedge clock); #1;
      imem_ack = (i == fd - 1);
      mem_ack = 1'($urandom_range(0, 1));
    end
    forever begin
      @(posedge clock); #1;
      guard++;
      if (state == 3'd0 || halted || trap) break;
      if (guard > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL instr_timeout: got state=%0d after %0d cycles expected FETCH", state, guard);
        break;
      end
      if (state == 3'd3) begin
        mem_ack = (mcnt >= md);
        mcnt++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      imem_ack = 1'($urandom_range(0, 1));
    end
    imem_ack = 1'b0;
  endtask

  task automatic settle(input kind_t k);
    if (k == K_HALT) begin
      repeat (3) begin
        @(posedge clock); #1;
        check("halt_pc_frozen", pc, mpc);
        check("halt_retire", 32'(retire), 32'd0);
      end
    end
    if (k != K_RETIRE) do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t k;
    imem_ack = 0; mem_ack = 0; is_jal = 0; is_jalr = 0; is_branch = 0; br_taken = 0;
    halt = 0; mem_op = 0; wb_en = 0; imm = '0; rs1_val = '0;
    do_reset();
    issue(0,0,0,0,0,0,1, 32'h0, 32'h0, 0, 0, k);              // 0 -> 4
    issue(0,0,0,0,0,0,1, 32'h0, 32'h0, 0, 0, k);              // 4 -> 8
    // Reset while in DECODE aborts the instruction.
    imem_ack = 1'b1; wb_en = 1'b1;
    @(posedge clock); #1;
    imem_ack = 1'b0;
    check("abort_in_decode", 32'(state), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_reg_write", 32'(reg_write), 32'd0);
    check("abort_pc", pc, RESET_PC);
    do_reset();
    issue(1,0,0,0,0,0,1, 32'h100, 32'h0, 0, 0, k);            // -> 0x100
    issue(0,0,1,1,0,0,0, 32'hFFFF_FFF0, 32'h0, 0, 0, k);      // -> 0xF0
    issue(1,0,0,0,0,0,0, 32'h10, 32'h0, 0, 0, k);             // -> 0x100
    issue(0,0,1,0,0,0,0, 32'hFFFF_FFF0, 32'h0, 0, 0, k);      // -> 0x104
    issue(0,1,0,0,0,0,0, 32'h0, 32'h40, 0, 0, k);             // -> 0x40
    issue(1,0,1,1,0,0,1, 32'h20, 32'h0, 0, 0, k);             // JAL wins -> 0x60
    issue(0,1,0,0,0,0,1, 32'h4, 32'h1001, 3, 0, k);           // -> 0x1004, latency 7
    issue(0,0,0,0,0,1,1, 32'h0, 32'h0, 0, 1, k);              // MEM,MEM -> 0x1008
    issue(0,1,0,0,0,0,0, 32'hC, 32'hFFFF_FFF0, 0, 0, k);      // -> 0xFFFFFFFC
    issue(0,0,0,0,0,0,1, 32'h0, 32'h0, 1, 0, k);              // wraps to 0
    issue(1,0,0,0,0,0,1, 32'h6, 32'h0, 0, 0, k);              // trap or 0x4
    settle(k);
    issue(0,0,0,0,1,0,1, 32'h0, 32'h0, 0, 0, k);              // halt
    settle(k);
    for (int n = 0; n < 80; n++) begin
      logic [31:0] r_imm, r_rs;
      r_imm = $urandom;
      r_rs  = $urandom;
      if ($urandom_range(0, 7) != 0) r_imm = r_imm & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) != 0) r_rs  = r_rs  & 32'hFFFF_FFFC;
      issue(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), r_imm, r_rs,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), k);
      settle(k);
    end
    repeat (2) @(posedge clock);
    #1;
    check("queue_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
